// File: rtl/wb_pipe_reg.sv
// Memory-to-writeback pipeline register with a short shift history of retired writebacks
// and a combinational forwarding lookup over all kept stages.
module wb_pipe_reg #(
  parameter int unsigned DATAW     = 32,
  parameter int unsigned REGW      = 5,
  parameter int unsigned PAYW      = 64,
  parameter int          DEPTH     = 2,
  parameter bit          SKIP_ZERO = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en_i,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic             wen_i,
  input  logic [REGW-1:0]  wsel_i,
  input  logic [DATAW-1:0] wdat_i,
  input  logic [PAYW-1:0]  pay_i,
  input  logic             halt_i,
  output logic             valid_o,
  output logic             wen_o,
  output logic [REGW-1:0]  wsel_o,
  output logic [DATAW-1:0] wdat_o,
  output logic [PAYW-1:0]  pay_o,
  output logic             halt_o,
  input  logic [REGW-1:0]  qsel_i,
  output logic             fwd_hit_o,
  output logic [DATAW-1:0] fwd_dat_o,
  output logic [1:0]       fwd_stg_o
);

  logic             valid_q [DEPTH];
  logic             wen_q   [DEPTH];
  logic [REGW-1:0]  wsel_q  [DEPTH];
  logic [DATAW-1:0] wdat_q  [DEPTH];
  logic [PAYW-1:0]  pay_q   [DEPTH];
  logic             halt_q;

  logic adv;
  logic set_halt;

  assign adv      = en_i & ~stall_i & ~halt_q;
  assign set_halt = adv & valid_i & halt_i & ~flush_i;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        wen_q[k]   <= 1'b0;
        wsel_q[k]  <= '0;
        wdat_q[k]  <= '0;
        pay_q[k]   <= '0;
      end
      halt_q <= 1'b0;
    end else begin
      if (adv) begin
        for (int k = 1; k < DEPTH; k++) begin
          valid_q[k] <= valid_q[k-1];
          wen_q[k]   <= wen_q[k-1];
          wsel_q[k]  <= wsel_q[k-1];
          wdat_q[k]  <= wdat_q[k-1];
          pay_q[k]   <= pay_q[k-1];
        end
        // A flushed advance loads a fully zeroed bubble.
        valid_q[0] <= valid_i & ~flush_i;
        wen_q[0]   <= wen_i & ~flush_i;
        wsel_q[0]  <= flush_i ? '0 : wsel_i;
        wdat_q[0]  <= flush_i ? '0 : wdat_i;
        pay_q[0]   <= flush_i ? '0 : pay_i;
      end else if (flush_i) begin
        // Flush overrides stall and halt, but only kills the live stage.
        valid_q[0] <= 1'b0;
        wen_q[0]   <= 1'b0;
      end
      if (set_halt) begin
        halt_q <= 1'b1;
      end
    end
  end

  assign valid_o = valid_q[0];
  assign wen_o   = valid_q[0] & wen_q[0];
  assign wsel_o  = wsel_q[0];
  assign wdat_o  = wdat_q[0];
  assign pay_o   = pay_q[0];
  assign halt_o  = halt_q;

  logic qzero;
  assign qzero = SKIP_ZERO && (qsel_i == '0);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_hit_o = 1'b0;
    fwd_dat_o = '0;
    fwd_stg_o = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (valid_q[k] && wen_q[k] && (wsel_q[k] == qsel_i) && !qzero) begin
        fwd_hit_o = 1'b1;
        fwd_dat_o = wdat_q[k];
        fwd_stg_o = 2'(k);
      end
    end
  end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Directed bench for wb_pipe_reg: DEPTH=2 and DEPTH=4 instances share stimulus and are
// checked every cycle against a queue-style history model plus literal expectations.
module tb_wb_pipe_reg;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        en = 1'b0, stall = 1'b0, flush = 1'b0, valid = 1'b0, wen = 1'b0, halt = 1'b0;
  logic [4:0]  wsel = '0, qsel = '0;
  logic [31:0] wdat = '0;
  logic [63:0] pay = '0;

  logic        a_valid, a_wen, a_halt, a_hit;
  logic [4:0]  a_wsel;
  logic [31:0] a_wdat, a_fdat;
  logic [63:0] a_pay;
  logic [1:0]  a_stg;
  logic        b_valid, b_wen, b_halt, b_hit;
  logic [4:0]  b_wsel;
  logic [31:0] b_wdat, b_fdat;
  logic [63:0] b_pay;
  logic [1:0]  b_stg;

  int total = 0;
  int bad = 0;

  always #5 CLK = ~CLK;

  wb_pipe_reg #(.DATAW(32), .REGW(5), .PAYW(64), .DEPTH(2), .SKIP_ZERO(1'b1)) dut_a (
    .CLK(CLK), .RST(RST), .en_i(en), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .wen_i(wen), .wsel_i(wsel), .wdat_i(wdat), .pay_i(pay), .halt_i(halt),
    .valid_o(a_valid), .wen_o(a_wen), .wsel_o(a_wsel), .wdat_o(a_wdat), .pay_o(a_pay),
    .halt_o(a_halt), .qsel_i(qsel), .fwd_hit_o(a_hit), .fwd_dat_o(a_fdat), .fwd_stg_o(a_stg)
  );

  wb_pipe_reg #(.DATAW(32), .REGW(5), .PAYW(64), .DEPTH(4), .SKIP_ZERO(1'b1)) dut_b (
    .CLK(CLK), .RST(RST), .en_i(en), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .wen_i(wen), .wsel_i(wsel), .wdat_i(wdat), .pay_i(pay), .halt_i(halt),
    .valid_o(b_valid), .wen_o(b_wen), .wsel_o(b_wsel), .wdat_o(b_wdat), .pay_o(b_pay),
    .halt_o(b_halt), .qsel_i(qsel), .fwd_hit_o(b_hit), .fwd_dat_o(b_fdat), .fwd_stg_o(b_stg)
  );

  // Model: per instance, a newest-first list of retired writebacks plus a halt flag.
  typedef struct packed {
    logic        v;
    logic        w;
    logic [4:0]  sel;
    logic [31:0] dat;
    logic [63:0] pay;
  } ent_t;

  ent_t m [2][4];
  bit   mh [2];
  int   dep [2] = '{2, 4};

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 4; k++) m[i][k] <= '0;
        mh[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (en && !stall && !mh[i]) begin
          for (int k = 1; k < dep[i]; k++) m[i][k] <= m[i][k-1];
          m[i][0] <= flush ? ent_t'(0) : ent_t'({valid, wen, wsel, wdat, pay});
          if (valid && halt && !flush) mh[i] <= 1'b1;
        end else if (flush) begin
          m[i][0].v <= 1'b0;
          m[i][0].w <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic v, input logic w, input logic [4:0] s,
                     input logic [31:0] d, input logic [63:0] p, input logic h,
                     input logic fh, input logic [31:0] fd, input logic [1:0] fs);
    logic        eh;
    logic [31:0] ed;
    logic [1:0]  es;
    eh = 1'b0;
    ed = '0;
    es = '0;
    for (int k = 0; k < dep[i]; k++) begin
      if (!eh && m[i][k].v && m[i][k].w && m[i][k].sel == qsel && qsel != 5'd0) begin
        eh = 1'b1;
        ed = m[i][k].dat;
        es = 2'(k);
      end
    end
    chk($sformatf("d%0d valid_o", dep[i]), 64'(v), 64'(m[i][0].v));
    chk($sformatf("d%0d wen_o", dep[i]), 64'(w), 64'(m[i][0].v & m[i][0].w));
    chk($sformatf("d%0d wsel_o", dep[i]), 64'(s), 64'(m[i][0].sel));
    chk($sformatf("d%0d wdat_o", dep[i]), 64'(d), 64'(m[i][0].dat));
    chk($sformatf("d%0d pay_o", dep[i]), p, m[i][0].pay);
    chk($sformatf("d%0d halt_o", dep[i]), 64'(h), 64'(mh[i]));
    chk($sformatf("d%0d fwd_hit", dep[i]), 64'(fh), 64'(eh));
    chk($sformatf("d%0d fwd_dat", dep[i]), 64'(fd), 64'(ed));
    chk($sformatf("d%0d fwd_stg", dep[i]), 64'(fs), 64'(es));
  endtask

  always @(negedge CLK) begin
    cmp(0, a_valid, a_wen, a_wsel, a_wdat, a_pay, a_halt, a_hit, a_fdat, a_stg);
    cmp(1, b_valid, b_wen, b_wsel, b_wdat, b_pay, b_halt, b_hit, b_fdat, b_stg);
  end

  task automatic cyc(input logic e, input logic s, input logic f, input logic v,
                     input logic w, input logic [4:0] sel, input logic [31:0] d,
                     input logic h);
    en = e; stall = s; flush = f; valid = v; wen = w; wsel = sel; wdat = d; halt = h;
    pay = {~d, d};
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #3;
    chk("rst valid_o", 64'(a_valid), 64'd0);
    chk("rst wdat_o", 64'(a_wdat), 64'd0);
    chk("rst halt_o", 64'(a_halt), 64'd0);
    chk("rst fwd_hit", 64'(a_hit), 64'd0);
    #9 RST = 1'b0;

    // Basic advance and history forwarding.
    cyc(1, 0, 0, 1, 1, 5'd5, 32'h11, 0);
    cyc(1, 0, 0, 1, 1, 5'd6, 32'h22, 0);
    cyc(1, 0, 0, 1, 1, 5'd7, 32'h33, 0);
    chk("adv wsel_o", 64'(a_wsel), 64'd7);
    chk("adv wdat_o", 64'(a_wdat), 64'h33);
    qsel = 5'd6; #1;
    chk("q6 hit", 64'(a_hit), 64'd1);
    chk("q6 dat", 64'(a_fdat), 64'h22);
    chk("q6 stg", 64'(a_stg), 64'd1);
    qsel = 5'd5; #1;
    chk("q5 miss", 64'(a_hit), 64'd0);
    chk("q5 dat", 64'(a_fdat), 64'd0);
    chk("q5 d4 stg", 64'(b_stg), 64'd2);

    // Stall holds everything.
    cyc(1, 0, 0, 1, 1, 5'd9, 32'hAA, 0);
    qsel = 5'd9;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 0, 1, 1, 5'(10 + i), 32'(32'h100 + i), 0);
      chk("stall wdat_o", 64'(a_wdat), 64'hAA);
      chk("stall fwd_stg", 64'(a_stg), 64'd0);
      chk("stall fwd_hit", 64'(a_hit), 64'd1);
    end

    // Flush with advance: bubble in stage 0, history shifts.
    cyc(1, 0, 0, 1, 1, 5'd3, 32'h10, 0);
    cyc(1, 0, 1, 1, 1, 5'd8, 32'h99, 0);
    chk("flush valid_o", 64'(a_valid), 64'd0);
    chk("flush wen_o", 64'(a_wen), 64'd0);
    chk("flush wsel_o", 64'(a_wsel), 64'd0);
    qsel = 5'd3; #1;
    chk("flush q3 stg", 64'(a_stg), 64'd1);
    chk("flush q3 dat", 64'(a_fdat), 64'h10);

    // Flush during stall: only valid/wen drop.
    cyc(1, 0, 0, 1, 1, 5'd12, 32'h5, 0);
    cyc(1, 1, 1, 1, 1, 5'd13, 32'h6, 0);
    chk("stflush valid_o", 64'(a_valid), 64'd0);
    chk("stflush wsel_o", 64'(a_wsel), 64'd12);
    chk("stflush wdat_o", 64'(a_wdat), 64'h5);
    qsel = 5'd12; #1;
    chk("stflush q12 miss", 64'(a_hit), 64'd0);

    // Youngest wins; register 0 never hits.
    cyc(1, 0, 0, 1, 1, 5'd4, 32'h1, 0);
    cyc(1, 0, 0, 1, 1, 5'd4, 32'h2, 0);
    qsel = 5'd4; #1;
    chk("q4 dat", 64'(a_fdat), 64'h2);
    chk("q4 stg", 64'(a_stg), 64'd0);
    cyc(1, 0, 0, 1, 1, 5'd0, 32'h77, 0);
    qsel = 5'd0; #1;
    chk("q0 nohit", 64'(a_hit), 64'd0);

    // DEPTH=4 sweep.
    for (int r = 1; r <= 5; r++) cyc(1, 0, 0, 1, 1, 5'(r), 32'(32'h100 + r), 0);
    for (int r = 1; r <= 5; r++) begin
      qsel = 5'(r); #1;
      chk($sformatf("sweep r%0d hit", r), 64'(b_hit), (r == 1) ? 64'd0 : 64'd1);
      chk($sformatf("sweep r%0d stg", r), 64'(b_stg), (r == 1) ? 64'd0 : 64'(5 - r));
      chk($sformatf("sweep r%0d dat", r), 64'(b_fdat), (r == 1) ? 64'd0 : 64'(32'h100 + r));
    end

    // Halt together with flush: flush wins.
    cyc(1, 0, 1, 1, 1, 5'd21, 32'h21, 1);
    chk("hflush halt_o", 64'(a_halt), 64'd0);

    // Sticky halt freezes everything.
    cyc(1, 0, 0, 1, 1, 5'd20, 32'hBEEF, 1);
    chk("halt halt_o", 64'(a_halt), 64'd1);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 1, 5'(22 + i), 32'(32'h300 + i), 0);
      chk("halted wdat_o", 64'(a_wdat), 64'hBEEF);
      chk("halted wsel_o", 64'(a_wsel), 64'd20);
      chk("halted valid_o", 64'(a_valid), 64'd1);
    end
    cyc(1, 0, 1, 1, 1, 5'd25, 32'h400, 0);
    chk("halted flush valid_o", 64'(a_valid), 64'd0);
    chk("halted flush wsel_o", 64'(a_wsel), 64'd20);
    chk("halted flush halt_o", 64'(a_halt), 64'd1);

    // Asynchronous reset mid-cycle.
    #2 RST = 1'b1;
    #1;
    chk("arst halt_o", 64'(a_halt), 64'd0);
    chk("arst wdat_o", 64'(a_wdat), 64'd0);
    chk("arst wsel_o", 64'(a_wsel), 64'd0);
    chk("arst d4 valid_o", 64'(b_valid), 64'd0);
    #3 RST = 1'b0;
    cyc(1, 0, 0, 1, 1, 5'd1, 32'h5A, 0);
    chk("post rst wdat_o", 64'(a_wdat), 64'h5A);
    cyc(0, 0, 0, 0, 0, 5'd0, 32'h0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_pipe_reg.md
# wb_pipe_reg

Parametrised memory-to-writeback pipeline register. It latches one instruction's writeback payload per advance and keeps a shift history of the last DEPTH retired writebacks, so the forwarding unit can source operands without extra delay copies. It supports stall, flush (bubble insertion) and sticky halt. It sits between the data-memory stage and the register file write port.

## Interface

Parameters:
- DATAW, 32, width of writeback data (ALU result / load data)
- REGW, 5, width of destination register index
- PAYW, 64, width of opaque side payload (pc4, instruction, control bits)
- DEPTH, 2, number of stages kept (stage 0 = live output, 1..DEPTH-1 = history); legal range 1..4
- SKIP_ZERO, 1, when 1, register index 0 never produces a forwarding hit

Ports:
- CLK  in  1  clock, all state on rising edge
- RST  in  1  asynchronous, active-high reset
- en_i  in  1  advance request (ihit | dhit from the caches)
- stall_i  in  1  hazard stall; holds every stage
- flush_i  in  1  insert bubble into stage 0
- valid_i  in  1  incoming instruction is real
- wen_i  in  1  incoming instruction writes the register file
- wsel_i  in  REGW  incoming destination register
- wdat_i  in  DATAW  incoming writeback data
- pay_i  in  PAYW  incoming side payload
- halt_i  in  1  incoming instruction is a halt
- valid_o  out  1  stage 0 valid
- wen_o  out  1  stage 0 register write enable, gated by valid_o
- wsel_o  out  REGW  stage 0 destination
- wdat_o  out  DATAW  stage 0 data
- pay_o  out  PAYW  stage 0 payload
- halt_o  out  1  sticky halt
- qsel_i  in  REGW  forwarding query register
- fwd_hit_o  out  1  query matched a stage
- fwd_dat_o  out  DATAW  data of youngest matching stage, 0 on miss
- fwd_stg_o  out  2  index of matching stage, 0 on miss

## Operation

- adv = en_i & ~stall_i & ~halt_o.
- On adv:
  - stage[k] <= stage[k-1] for k = 1..DEPTH-1.
  - stage 0 <= {valid_i & ~flush_i, wen_i, wsel_i, wdat_i, pay_i}.
  - When flush_i is high, stage 0 takes valid = 0 and wen = 0, and its data fields load zero.
- flush_i without adv: stage 0 valid and wen clear, the other fields hold, and history holds. A flush always overrides a stall for stage 0.
- No adv and no flush: all stages hold, including history. History therefore stays stable across whole stall cycles.
- Halt:
  - halt_o sets on adv when valid_i & halt_i & ~flush_i.
  - Once set it stays set until RST, and adv is blocked, so all stages freeze.
  - A flush while halted still clears stage 0 valid.
- Forwarding is combinational:
  - A stage k matches when valid[k] & wen[k] & (wsel[k] == qsel_i) & ~(SKIP_ZERO & qsel_i == 0).
  - The lowest k wins.
  - fwd_dat_o = wdat[k] and fwd_stg_o = k for the winning stage.
- wen_o = valid[0] & wen[0]. The other outputs are raw stage 0 fields.
- DEPTH = 1: no history; forwarding examines stage 0 only.

## Timing

- Reset: every stage field, valid_o, wen_o, wsel_o, wdat_o, pay_o, halt_o = 0. Forwarding outputs are 0 because no stage is valid.
- RST mid-stall or mid-halt clears everything immediately, without waiting for a clock edge.
- Latency: input to stage 0 outputs is 1 cycle after an adv edge. Stage 0 to history k is k further adv edges.
- Forwarding outputs are valid in the same cycle as qsel_i and stage contents change. There is no registered path.
- Simultaneous adv and flush: bubble enters stage 0 and history shifts in the same edge.
- Simultaneous halt_i and flush_i: flush wins, and no halt is set.
- Stage 0 and a history stage with the same wsel: stage 0 data is forwarded.

## Test plan

- Reset, then 3 adv cycles with valid=1, wen=1, wsel=5/6/7, wdat=0x11/0x22/0x33 (DEPTH=2) -> wsel_o=7, wdat_o=0x33. qsel=6 gives hit, dat=0x22, stg=1. qsel=5 gives a miss with dat=0.
- adv with wsel=9, wdat=0xAA, then stall_i=1 for 4 cycles with en_i=1 and new inputs applied -> outputs stay 0xAA throughout. qsel=9 hits stg=0 every cycle.
- Stage 0 wsel=3, wdat=0x10; then adv with flush_i=1 -> valid_o=0, wen_o=0. qsel=3 hits stg=1, dat=0x10.
- Consecutive writes to reg 4 with 0x1 then 0x2 -> qsel=4 returns 0x2, stg=0. With wsel=0, wen=1 and SKIP_ZERO=1, qsel=0 produces no hit.
- adv with halt_i=1, valid=1 -> halt_o=1 next cycle. Further adv attempts with new data leave all outputs unchanged. Asserting RST asynchronously drops halt_o and all outputs to 0 before the next edge.
- DEPTH=4 sweep: 5 writes to regs 1..5 -> regs 2..5 hit stg 3..0 respectively, and reg 1 misses.
